// File: rtl/xf100_exu_alu_arb.sv
// Two-port arbiter in front of the shared ALU, with a one-entry
// result register handed to writeback over valid/ready.
module xf100_exu_alu_arb #(
  parameter int XLEN     = 32,
  parameter int INFO_W   = 11,
  parameter int RFIDX_W  = 5,
  parameter int ARB_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [INFO_W-1:0]  req0_info,
  input  logic [XLEN-1:0]    req0_rs1,
  input  logic [XLEN-1:0]    req0_rs2,
  input  logic [XLEN-1:0]    req0_imm,
  input  logic               req0_rd_en,
  input  logic [RFIDX_W-1:0] req0_rdidx,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [INFO_W-1:0]  req1_info,
  input  logic [XLEN-1:0]    req1_rs1,
  input  logic [XLEN-1:0]    req1_rs2,
  input  logic [XLEN-1:0]    req1_imm,
  input  logic               req1_rd_en,
  input  logic [RFIDX_W-1:0] req1_rdidx,
  output logic [INFO_W-1:0]  alu_info,
  output logic [XLEN-1:0]    alu_rs1,
  output logic [XLEN-1:0]    alu_rs2,
  output logic [XLEN-1:0]    alu_imm,
  output logic               alu_rd_en,
  output logic [RFIDX_W-1:0] alu_rdidx,
  input  logic [XLEN-1:0]    alu_wbck_data,
  input  logic               alu_wbck_en,
  input  logic [RFIDX_W-1:0] alu_wbck_rdidx,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [XLEN-1:0]    o_data,
  output logic               o_wbck_en,
  output logic [RFIDX_W-1:0] o_rdidx,
  output logic               o_src
);

  localparam logic FIXED = (ARB_MODE == 1);

  logic w_can;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any;
  logic w_both;
  logic r_prio;

  assign w_can  = ~o_valid | o_ready;
  assign w_both = req0_valid & req1_valid;
  assign w_gnt0 = w_can & req0_valid &
                  (~req1_valid | FIXED | ~r_prio);
  assign w_gnt1 = w_can & req1_valid & ~w_gnt0;
  assign w_any  = w_gnt0 | w_gnt1;

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  assign alu_info  = w_gnt0 ? req0_info :
                     w_gnt1 ? req1_info :
                     '0;
  assign alu_rs1   = w_gnt0 ? req0_rs1   : req1_rs1;
  assign alu_rs2   = w_gnt0 ? req0_rs2   : req1_rs2;
  assign alu_imm   = w_gnt0 ? req0_imm   : req1_imm;
  assign alu_rd_en = w_gnt0 ? req0_rd_en : req1_rd_en;
  assign alu_rdidx = w_gnt0 ? req0_rdidx : req1_rdidx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_wbck_en <= 1'b0;
      o_rdidx   <= '0;
      o_src     <= 1'b0;
    end else if (w_any) begin
      o_valid   <= 1'b1;
      o_data    <= alu_wbck_data;
      o_wbck_en <= alu_wbck_en;
      o_rdidx   <= alu_wbck_rdidx;
      o_src     <= w_gnt1;
    end else if (o_valid & o_ready) begin
      o_valid   <= 1'b0;
    end
  end

  // Pointer names the loser of a contested grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (!FIXED && w_any && w_both) begin
      r_prio <= w_gnt0;
    end
  end

endmodule

// File: tb/tb_xf100_exu_alu_arb.sv
// Bench for xf100_exu_alu_arb: round-robin and fixed-priority
// instances against a queue-free behavioural model.
module tb_xf100_exu_alu_arb;

  localparam int XL = 32;
  localparam int IW = 11;
  localparam int RW = 5;

  logic clk;
  logic rst_n;

  logic          v0[2], v1[2], rdy0[2], rdy1[2];
  logic          rde0[2], rde1[2];
  logic [IW-1:0] inf0[2], inf1[2], ainfo[2];
  logic [XL-1:0] a0[2], b0[2], c0[2];
  logic [XL-1:0] a1[2], b1[2], c1[2];
  logic [XL-1:0] ars1[2], ars2[2], aimm[2];
  logic [XL-1:0] wdata[2], odata[2];
  logic [RW-1:0] rd0[2], rd1[2], ardidx[2];
  logic [RW-1:0] wrd[2], ordidx[2];
  logic          arden[2], wen[2], ov[2];
  logic          ordy[2], owen[2], osrc[2];

  logic          mv[2], mw[2], ms[2], mp[2];
  logic [XL-1:0] md[2];
  logic [RW-1:0] mr[2];
  logic          g0[2], g1[2];
  logic          s_rdy0[2], s_rdy1[2], s_ov[2], s_src[2];
  logic [XL-1:0] s_data[2];
  logic [RW-1:0] s_rd[2];

  int npass;
  int ntot;

  xf100_exu_alu_arb #(.ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]),
    .req0_info(inf0[0]), .req0_rs1(a0[0]),
    .req0_rs2(b0[0]), .req0_imm(c0[0]),
    .req0_rd_en(rde0[0]), .req0_rdidx(rd0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]),
    .req1_info(inf1[0]), .req1_rs1(a1[0]),
    .req1_rs2(b1[0]), .req1_imm(c1[0]),
    .req1_rd_en(rde1[0]), .req1_rdidx(rd1[0]),
    .alu_info(ainfo[0]), .alu_rs1(ars1[0]),
    .alu_rs2(ars2[0]), .alu_imm(aimm[0]),
    .alu_rd_en(arden[0]), .alu_rdidx(ardidx[0]),
    .alu_wbck_data(wdata[0]), .alu_wbck_en(wen[0]),
    .alu_wbck_rdidx(wrd[0]),
    .o_valid(ov[0]), .o_ready(ordy[0]),
    .o_data(odata[0]), .o_wbck_en(owen[0]),
    .o_rdidx(ordidx[0]), .o_src(osrc[0])
  );

  xf100_exu_alu_arb #(.ARB_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]),
    .req0_info(inf0[1]), .req0_rs1(a0[1]),
    .req0_rs2(b0[1]), .req0_imm(c0[1]),
    .req0_rd_en(rde0[1]), .req0_rdidx(rd0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]),
    .req1_info(inf1[1]), .req1_rs1(a1[1]),
    .req1_rs2(b1[1]), .req1_imm(c1[1]),
    .req1_rd_en(rde1[1]), .req1_rdidx(rd1[1]),
    .alu_info(ainfo[1]), .alu_rs1(ars1[1]),
    .alu_rs2(ars2[1]), .alu_imm(aimm[1]),
    .alu_rd_en(arden[1]), .alu_rdidx(ardidx[1]),
    .alu_wbck_data(wdata[1]), .alu_wbck_en(wen[1]),
    .alu_wbck_rdidx(wrd[1]),
    .o_valid(ov[1]), .o_ready(ordy[1]),
    .o_data(odata[1]), .o_wbck_en(owen[1]),
    .o_rdidx(ordidx[1]), .o_src(osrc[1])
  );

  function automatic logic [XL-1:0] alu_f(
    input logic [IW-1:0] info,
    input logic [XL-1:0] a, b, c);
    if (info[0])      return a + b;
    else if (info[1]) return a - b;
    else if (info[2]) return a + c;
    else              return a ^ b;
  endfunction

  always_comb begin
    for (int m = 0; m < 2; m++) begin
      wdata[m] = alu_f(ainfo[m], ars1[m], ars2[m], aimm[m]);
      wen[m]   = arden[m];
      wrd[m]   = ardidx[m];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [XL-1:0] act,
                     input logic [XL-1:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h required %0h",
                  nm, act, exp);
  endtask

  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; md[m] = '0; mw[m] = 0;
      mr[m] = '0; ms[m] = 0; mp[m] = 0;
      g0[m] = 0; g1[m] = 0;
    end
  endtask

  task automatic clr(input int m);
    v0[m] = 0;
    v1[m] = 0;
  endtask

  task automatic op0(input int m, input logic [IW-1:0] i,
                     input logic [XL-1:0] a, b,
                     input logic [RW-1:0] rd);
    v0[m] = 1; inf0[m] = i; a0[m] = a; b0[m] = b;
    c0[m] = '0; rde0[m] = 1; rd0[m] = rd;
  endtask

  task automatic op1(input int m, input logic [IW-1:0] i,
                     input logic [XL-1:0] a, b,
                     input logic [RW-1:0] rd);
    v1[m] = 1; inf1[m] = i; a1[m] = a; b1[m] = b;
    c1[m] = '0; rde1[m] = 1; rd1[m] = rd;
  endtask

  task automatic rnd_op(input int m, input int p);
    logic [IW-1:0] i;
    i = IW'(1) << $urandom_range(0, IW - 1);
    if (p == 0) begin
      op0(m, i, $urandom, $urandom, RW'($urandom));
      c0[m] = $urandom; rde0[m] = 1'($urandom);
    end else begin
      op1(m, i, $urandom, $urandom, RW'($urandom));
      c1[m] = $urandom; rde1[m] = 1'($urandom);
    end
  endtask

  // One cycle: compare at negedge, advance model, return at posedge+1.
  task automatic cyc();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      logic free, e0, e1;
      string pre;
      pre = (m == 0) ? "rr" : "fp";
      free = !mv[m] || ordy[m];
      e0 = 0;
      e1 = 0;
      if (free) begin
        if (v0[m] && v1[m]) begin
          if (m == 1 || !mp[m]) e0 = 1;
          else e1 = 1;
        end else begin
          e0 = v0[m];
          e1 = v1[m];
        end
      end
      s_rdy0[m] = rdy0[m]; s_rdy1[m] = rdy1[m];
      s_ov[m] = ov[m]; s_data[m] = odata[m];
      s_src[m] = osrc[m]; s_rd[m] = ordidx[m];
      chk({pre, "_req0_ready"}, XL'(rdy0[m]), XL'(e0));
      chk({pre, "_req1_ready"}, XL'(rdy1[m]), XL'(e1));
      chk({pre, "_o_valid"}, XL'(ov[m]), XL'(mv[m]));
      if (mv[m]) begin
        chk({pre, "_o_data"}, odata[m], md[m]);
        chk({pre, "_o_rdidx"}, XL'(ordidx[m]), XL'(mr[m]));
        chk({pre, "_o_wbck_en"}, XL'(owen[m]), XL'(mw[m]));
        chk({pre, "_o_src"}, XL'(osrc[m]), XL'(ms[m]));
      end
      if (!e0 && !e1)
        chk({pre, "_alu_info_idle"}, XL'(ainfo[m]), '0);
      if (e0 || e1) begin
        if (m == 0 && v0[m] && v1[m]) mp[m] = e0;
        mv[m] = 1;
        if (e0) begin
          md[m] = alu_f(inf0[m], a0[m], b0[m], c0[m]);
          mw[m] = rde0[m]; mr[m] = rd0[m]; ms[m] = 0;
        end else begin
          md[m] = alu_f(inf1[m], a1[m], b1[m], c1[m]);
          mw[m] = rde1[m]; mr[m] = rd1[m]; ms[m] = 1;
        end
      end else if (mv[m] && ordy[m]) begin
        mv[m] = 0;
      end
      g0[m] = e0;
      g1[m] = e1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    npass = 0;
    ntot = 0;
    mreset();
    for (int m = 0; m < 2; m++) begin
      clr(m);
      inf0[m] = '0; a0[m] = '0; b0[m] = '0; c0[m] = '0;
      inf1[m] = '0; a1[m] = '0; b1[m] = '0; c1[m] = '0;
      rde0[m] = 0; rde1[m] = 0; rd0[m] = '0; rd1[m] = '0;
      ordy[m] = 1;
    end
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_o_valid", XL'(ov[m]), '0);
      chk("rst_o_data", odata[m], '0);
      chk("rst_o_rdidx", XL'(ordidx[m]), '0);
      chk("rst_o_wbck_en", XL'(owen[m]), '0);
      chk("rst_o_src", XL'(osrc[m]), '0);
    end
    rst_n = 1;
    @(posedge clk);
    #1;

    op0(0, 11'd1, 5, 7, 5'd3);
    cyc();
    chk("t1_ready_same_cycle", XL'(s_rdy0[0]), 1);
    clr(0);
    cyc();
    chk("t1_o_valid", XL'(s_ov[0]), 1);
    chk("t1_o_data", s_data[0], 12);
    chk("t1_o_rdidx", XL'(s_rd[0]), 3);
    chk("t1_o_src", XL'(s_src[0]), 0);

    for (int m = 0; m < 2; m++) begin
      op0(m, 11'd1, 1, 2, 5'd1);
      op1(m, 11'd2, 20, 4, 5'd2);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("t2_rr_grant1", XL'(s_rdy1[0]), XL'(k % 2));
      if (k > 0)
        chk("t2_rr_src", XL'(s_src[0]), XL'((k - 1) % 2));
      if (k < 3) begin
        chk("t2_fp_grant0", XL'(s_rdy0[1]), 1);
        chk("t2_fp_ready1", XL'(s_rdy1[1]), 0);
      end
    end
    clr(0);
    v0[1] = 0;
    cyc();
    chk("t2_rr_last_src", XL'(s_src[0]), 1);
    chk("t2_fp_ready1_after", XL'(s_rdy1[1]), 1);
    clr(1);
    cyc();

    op0(0, 11'd1, 40, 2, 5'd4);
    cyc();
    clr(0);
    ordy[0] = 0;
    op1(0, 11'd2, 10, 3, 5'd9);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t3_stall_ready1", XL'(s_rdy1[0]), 0);
      chk("t3_stall_valid", XL'(s_ov[0]), 1);
      chk("t3_stall_data", s_data[0], 42);
    end
    ordy[0] = 1;
    cyc();
    chk("t3_release_ready1", XL'(s_rdy1[0]), 1);
    clr(0);
    cyc();
    chk("t3_o_data", s_data[0], 7);
    chk("t3_o_src", XL'(s_src[0]), 1);
    chk("t3_o_rdidx", XL'(s_rd[0]), 9);

    for (int i = 0; i < 9; i++) begin
      if (i < 8) op0(0, 11'd1, XL'(i), 1000, RW'(i));
      else clr(0);
      cyc();
      if (i < 8) chk("t4_ready0", XL'(s_rdy0[0]), 1);
      if (i > 0) begin
        chk("t4_valid", XL'(s_ov[0]), 1);
        chk("t4_data", s_data[0], XL'(i - 1 + 1000));
      end
    end
    cyc();
    chk("t4_drained", XL'(s_ov[0]), 0);

    op0(0, 11'd1, 3, 3, 5'd1);
    op1(0, 11'd1, 4, 4, 5'd2);
    cyc();
    chk("t5_pre_grant0", XL'(s_rdy0[0]), 1);
    clr(0);
    #1 rst_n = 0;
    #1;
    chk("t5_async_o_valid_rr", XL'(ov[0]), 0);
    chk("t5_async_o_valid_fp", XL'(ov[1]), 0);
    chk("t5_async_o_data", odata[0], 0);
    mreset();
    #1 rst_n = 1;
    op0(0, 11'd1, 8, 8, 5'd5);
    op1(0, 11'd1, 9, 9, 5'd6);
    cyc();
    chk("t5_post_reset_grant0", XL'(s_rdy0[0]), 1);
    clr(0);
    cyc();

    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 350) begin
        #1 rst_n = 0;
        #1;
        chk("rand_async_rr", XL'(ov[0]), 0);
        chk("rand_async_fp", XL'(ov[1]), 0);
        mreset();
        clr(0);
        clr(1);
        #1 rst_n = 1;
      end
      for (int m = 0; m < 2; m++) begin
        if (v0[m] && g0[m]) v0[m] = 0;
        if (v1[m] && g1[m]) v1[m] = 0;
        if (!v0[m] && ($urandom % 3 != 0)) rnd_op(m, 0);
        if (!v1[m] && ($urandom % 3 != 0)) rnd_op(m, 1);
        ordy[m] = ($urandom % 4 != 0);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/xf100_exu_alu_arb.md
Name: xf100_exu_alu_arb

Overview:
Shares the single combinational ALU datapath between two requesters: port 0 is EXU dispatch and port 1 is the branch-compare/address path.
- Arbitrates each cycle and drives the winner's operands onto the ALU inputs.
- Captures the ALU result into a one-entry output register tagged with the source port.
- Presents that register to writeback with a valid/ready handshake.
- Sits between dispatch/branch logic and the ALU; writeback consumes its output.

Parameters:
XLEN, 32, datapath width; matches `XF100_XLEN.
INFO_W, 11, ALU op-info vector width; matches `ALU_INFO_WIDTH.
RFIDX_W, 5, register index width; matches `XF100_RFIDX_WIDTH.
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with port 0 always winning.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid / req1_valid  in  1  requester has an op.
req0_ready / req1_ready  out  1  op accepted this cycle.
reqN_info  in  INFO_W  op-info one-hot vector.
reqN_rs1, reqN_rs2, reqN_imm  in  XLEN  operands.
reqN_rd_en  in  1  writeback enable.
reqN_rdidx  in  RFIDX_W  destination index.
alu_info  out  INFO_W  to ALU; all-zero when no grant.
alu_rs1, alu_rs2, alu_imm  out  XLEN  to ALU; selected requester's operands.
alu_rd_en  out  1  to ALU.
alu_rdidx  out  RFIDX_W  to ALU.
alu_wbck_data  in  XLEN  ALU result, same cycle.
alu_wbck_en  in  1  ALU result writeback enable, same cycle.
alu_wbck_rdidx  in  RFIDX_W  ALU result destination index, same cycle.
o_valid  out  1  result register holds an entry.
o_ready  in  1  writeback accepts.
o_data  out  XLEN  registered result.
o_wbck_en  out  1  registered writeback enable.
o_rdidx  out  RFIDX_W  registered destination index.
o_src  out  1  port that produced the entry.

Behaviour:
Reset values:
- o_valid=0; o_data, o_rdidx, o_wbck_en, o_src = 0.
- Priority pointer prio=0, meaning port 0 is preferred.

Accept and grant:
- can_accept = ~o_valid | o_ready. A result may be accepted in the same cycle the old one drains.
- gnt0 = can_accept & req0_valid & (~req1_valid | ARB_MODE==1 | prio==0).
- gnt1 = can_accept & req1_valid & ~gnt0.
- reqN_ready = gntN. Ready depends only on valids and state, never on operand values.
- ALU input mux: the gnt0 operands are selected when gnt0; otherwise the req1 operands are selected. alu_info is forced to zero when neither port is granted.

Result register:
- On gnt0|gnt1: o_data/o_wbck_en/o_rdidx are loaded from the ALU outputs, o_src is loaded with gnt1, and o_valid is set to 1.
- Otherwise, if o_valid & o_ready: o_valid is cleared to 0; data fields hold.
- Latency: request accept to o_valid is 1 cycle. Throughput is 1 op/cycle with o_ready held high.

Priority pointer:
- Round-robin mode: prio updates only on a grant, and only when both valids were high that cycle; it becomes the ungranted port.
- A lone request does not move prio.
- In fixed-priority mode prio is unused and is held at 0.

Requester protocol (bench-checked):
- Once reqN_valid is high it stays high with stable payload until reqN_ready.

Stall:
- With o_valid=1 and o_ready=0, both readies are 0 and the register holds.

Reset mid-operation:
- An asserted rst_n=0 clears o_valid immediately, asynchronously; a pending entry is dropped.
- Requesters re-issue after reset.

No combinational path from o_ready to alu_* outputs other than through the grant.

Test Plan:
- Single op: after reset, req0 ADD rs1=5, rs2=7, rdidx=3, o_ready=1 -> req0_ready=1 same cycle; next cycle o_valid=1, o_data=12, o_rdidx=3, o_src=0.
- Round-robin conflict, ARB_MODE=0: both valid for 4 cycles, o_ready=1 -> grants 0,1,0,1; o_src sequence 0,1,0,1.
- Fixed priority, ARB_MODE=1: both valid for 3 cycles -> port 0 granted 3 times; req1_ready stays 0 until req0_valid drops.
- Backpressure: entry held with o_ready=0 for 3 cycles while req1 SUB 10-3 is waiting -> req1_ready=0 throughout, o_data stable. On the cycle o_ready=1, req1 is granted; the next cycle o_data=7, o_src=1.
- Throughput: 8 back-to-back req0 ops with o_ready=1 -> 8 consecutive o_valid cycles, no bubbles, results in order.
- Async reset: assert rst_n low mid-cycle while o_valid=1 -> o_valid=0 before the next edge. After release, the first conflict grants port 0.
